// File: rtl/branch_predict_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : branch_predict_ctrl
// Purpose  : 2-bit saturating branch direction table with mispredict
//            redirect and IF/ID squash sequencing for the RV32I pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module branch_predict_ctrl #(
    parameter int XLEN         = 32,
    parameter int IDX_BITS     = 4,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_valid,
    input  logic [XLEN-1:0]  if_pc,
    output logic             pred_taken,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic             ex_pred_taken,
    input  logic             ex_taken,
    input  logic [XLEN-1:0]  ex_target,
    input  logic             stall,
    output logic             redirect,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             flush_if,
    output logic             flush_id,
    output logic             busy,
    output logic [CNT_W-1:0] mispredict_cnt
);

    localparam int         ENTRIES    = 1 << IDX_BITS;
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    logic [1:0]       r_cnt [ENTRIES];
    state_t           r_state;
    logic [2:0]       r_flush_cnt;
    logic             r_redirect;
    logic [XLEN-1:0]  r_redirect_pc;
    logic             r_busy;
    logic [CNT_W-1:0] r_mis_cnt;

    logic [IDX_BITS-1:0] w_if_idx;
    logic [IDX_BITS-1:0] w_ex_idx;
    logic                w_resolve;
    logic                w_mispred;
    logic                w_unused_if;

    assign w_if_idx    = if_pc[IDX_BITS+1:2];
    assign w_ex_idx    = ex_pc[IDX_BITS+1:2];
    assign w_unused_if = ^{if_pc[XLEN-1:IDX_BITS+2], if_pc[1:0]};

    // Branches seen while flushing are wrong-path and must not train or count.
    assign w_resolve = ex_valid & ex_is_branch & ~stall & (r_state == S_IDLE);
    assign w_mispred = w_resolve & (ex_taken != ex_pred_taken);

    assign pred_taken = r_cnt[w_if_idx][1] & if_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_cnt[i] <= 2'b01;
            end
        end else if (w_resolve) begin
            if (ex_taken) begin
                if (r_cnt[w_ex_idx] != 2'b11) begin
                    r_cnt[w_ex_idx] <= r_cnt[w_ex_idx] + 2'd1;
                end
            end else begin
                if (r_cnt[w_ex_idx] != 2'b00) begin
                    r_cnt[w_ex_idx] <= r_cnt[w_ex_idx] - 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_flush_cnt   <= 3'd0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
            r_busy        <= 1'b0;
            r_mis_cnt     <= '0;
        end else begin
            r_redirect <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_mispred) begin
                        r_redirect    <= 1'b1;
                        r_redirect_pc <= ex_taken ? ex_target : (ex_pc + XLEN'(4));
                        r_busy        <= 1'b1;
                        r_flush_cnt   <= FLUSH_LOAD;
                        r_state       <= S_FLUSH;
                        if (r_mis_cnt != '1) begin
                            r_mis_cnt <= r_mis_cnt + CNT_W'(1);
                        end
                    end
                end
                S_FLUSH: begin
                    if (!stall) begin
                        if (r_flush_cnt == 3'd0) begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_flush_cnt <= r_flush_cnt - 3'd1;
                        end
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign redirect       = r_redirect;
    assign redirect_pc    = r_redirect_pc;
    assign flush_if       = r_busy;
    assign flush_id       = r_busy;
    assign busy           = r_busy;
    assign mispredict_cnt = r_mis_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_predict_ctrl
// Purpose  : Directed + randomized bench for branch_predict_ctrl against a
//            behavioural predictor/flush model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_predict_ctrl;

    logic        clk;
    logic        rst_n;
    logic        if_valid;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic        ex_valid;
    logic        ex_is_branch;
    logic [31:0] ex_pc;
    logic        ex_pred_taken;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush_if;
    logic        flush_id;
    logic        busy;
    logic [15:0] mispredict_cnt;

    branch_predict_ctrl u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .ex_valid       (ex_valid),
        .ex_is_branch   (ex_is_branch),
        .ex_pc          (ex_pc),
        .ex_pred_taken  (ex_pred_taken),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .flush_if       (flush_if),
        .flush_id       (flush_id),
        .busy           (busy),
        .mispredict_cnt (mispredict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: counter values 0..3 and number of flush cycles left.
    int          m_cnt [16];
    int          m_left;
    bit          m_redir;
    logic [31:0] m_rpc;
    int          m_mcnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    function automatic int idx(input logic [31:0] pc);
        return int'(pc[5:2]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_cnt[i] = 1;
        m_left  = 0;
        m_redir = 0;
        m_rpc   = 32'h0;
        m_mcnt  = 0;
    endtask

    task automatic model_edge();
        bit busy_now, resolve, mis;
        int i;
        busy_now = (m_left > 0);
        resolve  = ex_valid && ex_is_branch && !stall && !busy_now;
        mis      = resolve && (ex_taken != ex_pred_taken);
        m_redir  = mis;
        if (resolve) begin
            i = idx(ex_pc);
            if (ex_taken) m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
            else          m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
        end
        if (busy_now && !stall) m_left--;
        if (mis) begin
            m_rpc  = ex_taken ? ex_target : ex_pc + 32'd4;
            m_left = 2;
            m_mcnt = (m_mcnt < 65535) ? m_mcnt + 1 : 65535;
        end
    endtask

    task automatic check_outs();
        chk("redirect", {31'b0, redirect}, {31'b0, m_redir});
        if (m_redir) chk("redirect_pc", redirect_pc, m_rpc);
        chk("flush_if", {31'b0, flush_if}, {31'b0, m_left > 0});
        chk("flush_id", {31'b0, flush_id}, {31'b0, m_left > 0});
        chk("busy", {31'b0, busy}, {31'b0, m_left > 0});
        chk("mispredict_cnt", {16'b0, mispredict_cnt}, m_mcnt);
    endtask

    // Inputs are set at the falling edge before calling; one full clock.
    task automatic step();
        #1;
        chk("pred_taken", {31'b0, pred_taken}, {31'b0, if_valid && (m_cnt[idx(if_pc)] >= 2)});
        @(posedge clk);
        model_edge();
        #1;
        check_outs();
        @(negedge clk);
    endtask

    task automatic set_br(input logic [31:0] pc, input logic pred, input logic tkn,
                          input logic [31:0] tgt);
        ex_valid      = 1'b1;
        ex_is_branch  = 1'b1;
        ex_pc         = pc;
        ex_pred_taken = pred;
        ex_taken      = tkn;
        ex_target     = tgt;
    endtask

    task automatic idle_ex();
        ex_valid     = 1'b0;
        ex_is_branch = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; if_valid = 1'b0; if_pc = 32'h0; stall = 1'b0;
        ex_valid = 1'b0; ex_is_branch = 1'b0; ex_pc = 32'h0;
        ex_pred_taken = 1'b0; ex_taken = 1'b0; ex_target = 32'h0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outs();
        rst_n = 1'b1;

        // Reset state and first mispredict (taken)
        if_valid = 1'b1; if_pc = 32'h40;
        step();
        set_br(32'h40, 1'b0, 1'b1, 32'h80);
        step();
        idle_ex();
        repeat (3) step();

        // Training at 0x44 with the table's own prediction, then one not-taken
        if_pc = 32'h44;
        for (int k = 0; k < 3; k++) begin
            set_br(32'h44, m_cnt[idx(32'h44)] >= 2, 1'b1, 32'h100);
            step();
            idle_ex();
            repeat (3) step();
        end
        set_br(32'h44, 1'b1, 1'b0, 32'h100);
        step();
        idle_ex();
        repeat (3) step();

        // Not-taken mispredict with PC wrap, wrong-path branch, stall mid-flush
        set_br(32'hFFFF_FFFC, 1'b1, 1'b0, 32'h1234);
        step();
        set_br(32'h10, 1'b1, 1'b0, 32'h0);
        stall = 1'b1;
        repeat (3) step();
        stall = 1'b0;
        step();
        idle_ex();
        repeat (3) step();

        // Reset asserted mid-flush
        set_br(32'h48, 1'b0, 1'b1, 32'h200);
        step();
        idle_ex();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outs();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if_pc = 32'(i * 4);
            step();
        end

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [31:0] pc;
            pc = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : 32'(32'h40 + 4 * $urandom_range(0, 7));
            if_valid      = ($urandom_range(0, 9) != 0);
            if_pc         = 32'(4 * $urandom_range(0, 15));
            stall         = ($urandom_range(0, 99) < 15);
            ex_valid      = ($urandom_range(0, 9) < 7);
            ex_is_branch  = ($urandom_range(0, 9) < 8);
            ex_pc         = pc;
            ex_taken      = $urandom_range(0, 1) == 1;
            ex_target     = $urandom;
            ex_pred_taken = ($urandom_range(0, 9) < 7) ? (m_cnt[idx(pc)] >= 2)
                                                       : ($urandom_range(0, 1) == 1);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
